// File: rtl/ascon_pack.sv
// ============================================================================
// Module      : ascon_pack
// Description : Shared Ascon types, round counts and round-constant helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascon_pack;

  localparam int PA_ROUNDS = 12;
  localparam int PB_ROUNDS = 6;

  // Word i of the state is element [i]; word 0 is the rate word.
  typedef logic [4:0][63:0] type_state;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_t;

  function automatic logic [7:0] round_const(input logic [3:0] r);
    logic [3:0] hi;
    hi = 4'hF - r;
    return {hi, r};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ascon_round.sv
// ============================================================================
// Module      : ascon_round
// Description : One combinational Ascon round: constant add, S-box, diffusion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascon_round
  import ascon_pack::*;
(
  input  type_state   state_in,
  input  logic [3:0]  round_idx,
  output type_state   state_out
);

  type_state w_a;
  type_state w_b;
  type_state w_c;

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  assign w_a[0] = state_in[0] ^ state_in[4];
  assign w_a[1] = state_in[1];
  assign w_a[2] = state_in[2] ^ {56'd0, round_const(round_idx)} ^ state_in[1];
  assign w_a[3] = state_in[3];
  assign w_a[4] = state_in[4] ^ state_in[3];

  assign w_b[0] = w_a[0] ^ (~w_a[1] & w_a[2]);
  assign w_b[1] = w_a[1] ^ (~w_a[2] & w_a[3]);
  assign w_b[2] = w_a[2] ^ (~w_a[3] & w_a[4]);
  assign w_b[3] = w_a[3] ^ (~w_a[4] & w_a[0]);
  assign w_b[4] = w_a[4] ^ (~w_a[0] & w_a[1]);

  assign w_c[0] = w_b[0] ^ w_b[4];
  assign w_c[1] = w_b[1] ^ w_b[0];
  assign w_c[2] = ~w_b[2];
  assign w_c[3] = w_b[3] ^ w_b[2];
  assign w_c[4] = w_b[4];

  // Linear layer: each word XORed with two right-rotations of itself.
  assign state_out[0] = w_c[0] ^ {w_c[0][18:0], w_c[0][63:19]} ^ {w_c[0][27:0], w_c[0][63:28]};
  assign state_out[1] = w_c[1] ^ {w_c[1][60:0], w_c[1][63:61]} ^ {w_c[1][38:0], w_c[1][63:39]};
  assign state_out[2] = w_c[2] ^ {w_c[2][0],    w_c[2][63:1]}  ^ {w_c[2][5:0],  w_c[2][63:6]};
  assign state_out[3] = w_c[3] ^ {w_c[3][9:0],  w_c[3][63:10]} ^ {w_c[3][16:0], w_c[3][63:17]};
  assign state_out[4] = w_c[4] ^ {w_c[4][6:0],  w_c[4][63:7]}  ^ {w_c[4][40:0], w_c[4][63:41]};

endmodule

`default_nettype wire

// File: rtl/permutation_unrolled.sv
// ============================================================================
// Module      : permutation_unrolled
// Description : Iterative Ascon pa/pb engine, UNROLL rounds per clock, with
//               begin-XOR absorb and optional key end-XOR (ASCON_XOR_END_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module permutation_unrolled
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         pa_i,
  input  logic         sel_ext_i,
  input  type_state    state_i,
  input  logic         absorb_i,
  input  logic [63:0]  data_i,
  input  logic         key_end_i,
  input  logic [127:0] key_i,
  output logic         ready_o,
  output logic         done_o,
  output type_state    state_o,
  output logic [63:0]  C_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
    $error("permutation_unrolled: UNROLL must be 1, 2, 3 or 6");
  end

  localparam logic [3:0] STEP = 4'(UNROLL);

  fsm_state_t  r_fsm;
  logic [3:0]  r_cnt;
  type_state   r_state;
  logic [63:0] r_c;
  logic        r_ready;
  logic        r_done;

  type_state   w_src;
  type_state   w_x;
  type_state   w_in;
  type_state   w_result;
  type_state   w_chain [UNROLL+1];
  logic        w_idle;
  logic [3:0]  w_base;
  logic [3:0]  w_next_cnt;
  logic        w_last;

  always_comb begin
    w_src = sel_ext_i ? state_i : r_state;
    w_x   = w_src;
    if (absorb_i) w_x[0] = w_src[0] ^ data_i;
  end

  // In IDLE the chain works on the accept-time source; in RUN on the register.
  assign w_idle     = (r_fsm == IDLE);
  assign w_in       = w_idle ? w_x : r_state;
  assign w_base     = w_idle ? (pa_i ? 4'd0 : 4'(PA_ROUNDS - PB_ROUNDS)) : r_cnt;
  assign w_next_cnt = w_base + STEP;
  assign w_last     = (w_next_cnt == 4'(PA_ROUNDS));

  assign w_chain[0] = w_in;

  for (genvar i = 0; i < UNROLL; i++) begin : g_round
    ascon_round u_round (
      .state_in  (w_chain[i]),
      .round_idx (w_base + 4'(i)),
      .state_out (w_chain[i+1])
    );
  end

`ifdef ASCON_XOR_END_EN
  logic r_key_end;
  logic w_key_end;

  assign w_key_end = w_idle ? key_end_i : r_key_end;

  always_comb begin
    w_result = w_chain[UNROLL];
    if (w_last && w_key_end) begin
      w_result[3] = w_chain[UNROLL][3] ^ key_i[127:64];
      w_result[4] = w_chain[UNROLL][4] ^ key_i[63:0];
    end
  end
`else
  logic w_unused_key;
  assign w_unused_key = ^{key_end_i, key_i};
  assign w_result     = w_chain[UNROLL];
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= 4'd0;
      r_state <= '0;
      r_c     <= 64'd0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
`ifdef ASCON_XOR_END_EN
      r_key_end <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start_i) begin
            r_state <= w_result;
            r_c     <= w_x[0];
            r_cnt   <= w_next_cnt;
`ifdef ASCON_XOR_END_EN
            r_key_end <= key_end_i;
`endif
            // A single-cycle permutation finishes on its own accept edge.
            if (w_last) begin
              r_done <= 1'b1;
            end else begin
              r_fsm   <= RUN;
              r_ready <= 1'b0;
            end
          end
        end
        RUN: begin
          r_state <= w_result;
          r_cnt   <= w_next_cnt;
          if (w_last) begin
            r_fsm   <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_fsm   <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign state_o = r_state;
  assign C_o     = r_c;

endmodule

`default_nettype wire

// File: tb/tb_permutation_unrolled.sv
// ============================================================================
// Module      : tb_permutation_unrolled
// Description : Self-checking bench over UNROLL 1/2/3/6 against a table-driven
//               Ascon reference model (honours ASCON_XOR_END_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_permutation_unrolled;
  import ascon_pack::*;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  typedef struct {
    logic         pa;
    logic         absorb;
    logic         key_end;
    type_state    st;
    logic [63:0]  data;
    logic [127:0] key;
    type_state    exp;
    logic [63:0]  exp_c;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start [4];
  logic         pa, sel_ext, absorb, key_end;
  type_state    state_in;
  logic [63:0]  data;
  logic [127:0] key;
  logic         rdy [4];
  logic         dn  [4];
  type_state    st  [4];
  logic [63:0]  cw  [4];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    permutation_unrolled #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : 6)) u_dut (
      .clock_i   (clk),
      .reset_i   (rst),
      .start_i   (start[g]),
      .pa_i      (pa),
      .sel_ext_i (sel_ext),
      .state_i   (state_in),
      .absorb_i  (absorb),
      .data_i    (data),
      .key_end_i (key_end),
      .key_i     (key),
      .ready_o   (rdy[g]),
      .done_o    (dn[g]),
      .state_o   (st[g]),
      .C_o       (cw[g])
    );
  end

  function automatic int unr(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Reference: table S-box per bit column, rounds 12-n .. 11.
  function automatic type_state model_perm(input type_state s, input int n);
    type_state x, y;
    logic [4:0] col, o;
    x = s;
    y = '0;
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'((15 - r) * 16 + r);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        o = SBOX[col];
        y[0][b] = o[4]; y[1][b] = o[3]; y[2][b] = o[2]; y[3][b] = o[1]; y[4][b] = o[0];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    return x;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge with all DUTs idle.
  task automatic run_vec(input int idx, input vec_t v);
    int        done_at [4];
    int        pulses  [4];
    logic      rdy_ok  [4];
    type_state got     [4];
    logic [63:0] c1    [4];
    int        lat;
    pa = v.pa; sel_ext = 1'b1; absorb = v.absorb; key_end = v.key_end;
    state_in = v.st; data = v.data; key = v.key;
    for (int g = 0; g < 4; g++) begin
      start[g] = 1'b1; done_at[g] = 0; pulses[g] = 0; rdy_ok[g] = 1'b1; got[g] = '0; c1[g] = '0;
    end
    @(negedge clk);
    for (int g = 0; g < 4; g++) start[g] = 1'b0;
    for (int j = 1; j <= 13; j++) begin
      for (int g = 0; g < 4; g++) begin
        lat = (v.pa ? 12 : 6) / unr(g);
        if (j == 1) c1[g] = cw[g];
        if (dn[g] === 1'b1) begin
          pulses[g]++;
          if (done_at[g] == 0) begin done_at[g] = j; got[g] = st[g]; end
        end
        if (rdy[g] !== ((j >= lat) ? 1'b1 : 1'b0)) rdy_ok[g] = 1'b0;
      end
      @(negedge clk);
    end
    for (int g = 0; g < 4; g++) begin
      lat = (v.pa ? 12 : 6) / unr(g);
      check($sformatf("v%0d_u%0d_latency", idx, unr(g)), 320'(done_at[g]), 320'(lat));
      check($sformatf("v%0d_u%0d_done_pulses", idx, unr(g)), 320'(pulses[g]), 320'd1);
      check($sformatf("v%0d_u%0d_ready", idx, unr(g)), 320'(rdy_ok[g]), 320'd1);
      check($sformatf("v%0d_u%0d_state", idx, unr(g)), got[g], v.exp);
      check($sformatf("v%0d_u%0d_c", idx, unr(g)), 320'(c1[g]), 320'(v.exp_c));
    end
  endtask

  task automatic wait_done(input int g, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (dn[g] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  // pa then chained pb on the done cycle, with a start pulse ignored in RUN.
  task automatic chain_test(input int g);
    type_state s, exp2;
    logic seen;
    s = rand_state();
    exp2 = model_perm(model_perm(s, 12), 6);
    pa = 1'b1; sel_ext = 1'b1; absorb = 1'b0; key_end = 1'b0; state_in = s;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    wait_done(g, seen);
    check($sformatf("chain_u%0d_first_done", unr(g)), 320'(seen), 320'd1);
    check($sformatf("chain_u%0d_ready_on_done", unr(g)), 320'(rdy[g]), 320'd1);
    pa = 1'b0; sel_ext = 1'b0; start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    if (rdy[g] === 1'b0) begin
      pa = 1'b1; sel_ext = 1'b1; state_in = rand_state(); start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
    end
    wait_done(g, seen);
    check($sformatf("chain_u%0d_second_done", unr(g)), 320'(seen), 320'd1);
    check($sformatf("chain_u%0d_state", unr(g)), st[g], exp2);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    type_state x;
    rst = 1'b1; pa = 1'b0; sel_ext = 1'b0; absorb = 1'b0; key_end = 1'b0;
    state_in = '0; data = '0; key = '0;
    for (int g = 0; g < 4; g++) start[g] = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("reset_u%0d_state", unr(g)), st[g], '0);
      check($sformatf("reset_u%0d_c", unr(g)), 320'(cw[g]), '0);
      check($sformatf("reset_u%0d_ready_done", unr(g)), 320'({rdy[g], dn[g]}), 320'b10);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{pa: 1'b1, absorb: 1'b0, key_end: 1'b0, st: '0, data: 64'd0, key: 128'd0, exp: '0, exp_c: 64'd0};
    vecs[1] = '{pa: 1'b0, absorb: 1'b1, key_end: 1'b0, st: '0, data: 64'hFFFF_FFFF_FFFF_FFFF, key: 128'd0, exp: '0, exp_c: 64'd0};
    vecs[1].st[0] = 64'h0123_4567_89AB_CDEF;
    vecs[2] = '{pa: 1'b1, absorb: 1'b0, key_end: 1'b1, st: rand_state(),
                data: 64'd0, key: 128'h000102030405060708090A0B0C0D0E0F, exp: '0, exp_c: 64'd0};
    vecs[3] = '{pa: 1'b0, absorb: 1'b1, key_end: 1'b1, st: rand_state(),
                data: {$urandom(), $urandom()}, key: {$urandom(), $urandom(), $urandom(), $urandom()}, exp: '0, exp_c: 64'd0};
    for (int i = 4; i < 8; i++)
      vecs[i] = '{pa: 1'($urandom_range(0, 1)), absorb: 1'($urandom_range(0, 1)), key_end: 1'($urandom_range(0, 1)),
                  st: rand_state(), data: {$urandom(), $urandom()},
                  key: {$urandom(), $urandom(), $urandom(), $urandom()}, exp: '0, exp_c: 64'd0};

    for (int i = 0; i < 8; i++) begin
      x = vecs[i].st;
      if (vecs[i].absorb) x[0] = x[0] ^ vecs[i].data;
      vecs[i].exp_c = x[0];
      vecs[i].exp = model_perm(x, vecs[i].pa ? 12 : 6);
`ifdef ASCON_XOR_END_EN
      if (vecs[i].key_end) begin
        vecs[i].exp[3] = vecs[i].exp[3] ^ vecs[i].key[127:64];
        vecs[i].exp[4] = vecs[i].exp[4] ^ vecs[i].key[63:0];
      end
`endif
    end
    check("absorb_c_constant", 320'(vecs[1].exp_c), 320'(64'hFEDC_BA98_7654_3210));

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);
    for (int g = 0; g < 4; g++) chain_test(g);

    // Asynchronous reset in the middle of a pa run.
    pa = 1'b1; sel_ext = 1'b1; absorb = 1'b0; key_end = 1'b0; state_in = rand_state();
    for (int g = 0; g < 4; g++) start[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 4; g++) start[g] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      check($sformatf("midreset_u%0d_state", unr(g)), st[g], '0);
      check($sformatf("midreset_u%0d_c", unr(g)), 320'(cw[g]), '0);
      check($sformatf("midreset_u%0d_ready_done", unr(g)), 320'({rdy[g], dn[g]}), 320'b10);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++)
      check($sformatf("postreset_u%0d_idle", unr(g)), 320'({rdy[g], dn[g]}), 320'b10);
    run_vec(8, vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/permutation_unrolled.md
# permutation_unrolled

Parametrised, iterative Ascon permutation engine. It runs the pa (12-round) or pb (6-round) permutation over the 320-bit state in 12/UNROLL or 6/UNROLL clock cycles under a start/done handshake, with an internal round counter. It performs the begin-XOR of 64-bit data (absorb, with registered ciphertext word) and an optional end-XOR of the key. It sits between the Ascon control FSM and the state register path, and replaces the single-round, externally sequenced permutation step.

## Interface
- UNROLL, 1, rounds computed per clock; legal values 1, 2, 3, 6 (must divide 6 and 12); elaboration error otherwise
- clock_i  in  1  system clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  request a permutation; accepted only when ready_o=1
- pa_i  in  1  1: 12 rounds (pa), 0: 6 rounds (pb); sampled at accept
- sel_ext_i  in  1  1: source state is state_i, 0: internal state register; sampled at accept
- state_i  in  320 (type_state)  external source state
- absorb_i  in  1  1: XOR data_i into word 0 before round 1
- data_i  in  64  data word for absorb
- key_end_i  in  1  1: XOR key_i into words 3,4 after last round
- key_i  in  128  key; key_i[127:64] into word 3, key_i[63:0] into word 4
- ready_o  out  1  engine idle, can accept start_i
- done_o  out  1  one-cycle pulse: state_o holds the final result
- state_o  out  320 (type_state)  internal state register
- C_o  out  64  registered word 0 after data XOR (ciphertext/tag word)

## Operation
- FSM states: IDLE (ready_o=1), RUN (ready_o=0).
- Accept: start_i=1 and ready_o=1 at a rising edge.
  - src = sel_ext_i ? state_i : state_o.
  - x = src with word 0 ^= data_i if absorb_i.
  - C_o <= x[0].
  - Register <= UNROLL rounds applied to x.
  - pa_i and key_end_i are latched. Counter r0 = 12 - N, where N = pa_i ? 12 : 6.
- RUN: each edge applies UNROLL rounds to state_o. The round index advances by UNROLL.
- Round constant for index r (0..11): {4'hF - r, r}, XORed into word 2 low byte.
- The last stage of the final cycle applies the end key XOR if latched key_end_i=1. Same edge: FSM -> IDLE, done_o <= 1.
- start_i during RUN is ignored; no queueing.
- start_i while done_o=1 is accepted (back-to-back). done_o still pulses for exactly one cycle.
- sel_ext_i=0 chains on the previous result, for absorb loops.
- Reset mid-RUN: immediately IDLE. All registers go to reset values and the result is lost.

## Timing
- Reset values: state_o=0, C_o=0, ready_o=1, done_o=0, counter=0, FSM=IDLE.
- Latency: N/UNROLL edges from accept edge (inclusive) to result in state_o. done_o is high during the cycle after the final edge.
- Example, UNROLL=1, pa: accept at edge 0, result at edge 11, done_o high cycles 12..12. For UNROLL=1 pb: 6 edges.
- Special case: UNROLL=6, pb completes at the accept edge. FSM stays IDLE, done_o pulses next cycle, ready_o never drops.
- C_o is valid from the cycle after accept until the next accept.
- Combinational depth: UNROLL round functions plus begin/end XOR.

## Configuration
- ASCON_XOR_END_EN defined: key end-XOR is present as described.
- Not defined: key_end_i and key_i are ignored (ports kept) and no end-XOR logic is built.

## Structure
- ascon_pack holds:
  - type_state
  - the round-constant function
  - the constants 12 (PA_ROUNDS) and 6 (PB_ROUNDS)
- Sub-module ascon_round: one combinational round (constant add, S-box layer, linear diffusion) with inputs state and round index. It is instantiated UNROLL times in a chain.
- The FSM, counter, XORs and registers stay in permutation_unrolled.

## Test plan
- Reset: assert reset_i mid-cycle -> state_o=0, C_o=0, ready_o=1, done_o=0 immediately (async).
- UNROLL=1, pa_i=1, sel_ext_i=1, state_i=0, absorb_i=0 -> ready_o low 11 cycles, done_o single pulse 12 cycles after accept. state_o matches the Ascon software model of p12(0).
- Absorb with state_i word0=0x0123456789ABCDEF, data_i=0xFFFFFFFFFFFFFFFF -> C_o=0xFEDCBA9876543210 the cycle after accept. The result matches the model p6 for pb.
- Chained: second start with sel_ext_i=0 on the done_o cycle -> accepted, and the result equals the model p6(p12(state)). start_i pulsed during RUN changes nothing.
- key_end_i=1, key_i=128'h000102…0F, with ASCON_XOR_END_EN -> words 3/4 equal the model ^ key. Without the macro -> equal the model result unchanged.
- Sweep UNROLL ∈ {1,2,3,6} × {pa,pb} -> latency N/UNROLL and identical state_o. A reset during RUN at cycle 3 returns to IDLE with state_o=0.
